// File: rtl/mips_pkg.sv
// Shared MIPS decode-stage definitions: register file geometry, well-known
// register indices and the address/word types used by the register file.
package mips_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam reg_addr_t REG_ZERO = reg_addr_t'(0);
  localparam reg_addr_t REG_RA   = reg_addr_t'(31);

  // True when an enabled access targets a real (non-zero) register at 'addr'.
  function automatic logic addr_match(input logic en, input reg_addr_t a, input reg_addr_t addr);
    return en && (a == addr) && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_file_entry.sv
// One general-purpose register: DATA_WIDTH flops with load enable and an
// asynchronous active-low reset to a configurable value.
module reg_file_entry #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// MIPS register file with write-back bypass and a per-register busy scoreboard
// used by decode to stall on RAW hazards. Entry 0 is hardwired to zero.
module register_file_sb #(
  parameter int                    DATA_WIDTH  = mips_pkg::DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = mips_pkg::ADDR_WIDTH,
  parameter int                    NUM_REGS    = mips_pkg::NUM_REGS,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  output logic                  busy_a,
  output logic                  busy_b,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_dest
);

  import mips_pkg::*;

  logic [NUM_REGS-1:1]                 wr_hit;
  logic [NUM_REGS-1:1]                 iss_hit;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] entry_q;
  logic [NUM_REGS-1:1]                 busy_q;
  logic [NUM_REGS-1:0]                 busy;
  logic                                bypass_a;
  logic                                bypass_b;
  logic                                wb_hit_a;
  logic                                wb_hit_b;

  assign entry_q[0] = '0;

  generate
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
      assign wr_hit[r]  = write_enable && (write_addr == ADDR_WIDTH'(r));
      assign iss_hit[r] = issue_valid  && (issue_dest == ADDR_WIDTH'(r));

      reg_file_entry #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VALUE (RESET_VALUE)
      ) u_entry (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (wr_hit[r]),
        .d       (write_data),
        .q       (entry_q[r])
      );

      // A newer producer issuing this cycle outranks the older one retiring.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          busy_q[r] <= 1'b0;
        end else if (iss_hit[r]) begin
          busy_q[r] <= 1'b1;
        end else if (wr_hit[r]) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  endgenerate

  assign busy = {busy_q, 1'b0};

  assign wb_hit_a = write_enable && (write_addr == read_addr_a);
  assign wb_hit_b = write_enable && (write_addr == read_addr_b);
  assign bypass_a = wb_hit_a && (read_addr_a != REG_ZERO);
  assign bypass_b = wb_hit_b && (read_addr_b != REG_ZERO);

  always_comb begin
    read_data_a = entry_q[read_addr_a];
    if (read_addr_a == REG_ZERO) begin
      read_data_a = '0;
    end else if (bypass_a) begin
      read_data_a = write_data;
    end
  end

  always_comb begin
    read_data_b = entry_q[read_addr_b];
    if (read_addr_b == REG_ZERO) begin
      read_data_b = '0;
    end else if (bypass_b) begin
      read_data_b = write_data;
    end
  end

  // The write-back landing this cycle already satisfies the hazard.
  assign busy_a = busy[read_addr_a] && !wb_hit_a;
  assign busy_b = busy[read_addr_b] && !wb_hit_b;

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: a behavioural model predicts each
// cycle's combinational outputs, which are queued and checked against the DUT.
module tb_register_file_sb;

  logic        clock;
  logic        reset_n;
  logic [4:0]  read_addr_a;
  logic [4:0]  read_addr_b;
  logic [31:0] read_data_a;
  logic [31:0] read_data_b;
  logic        busy_a;
  logic        busy_b;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        issue_valid;
  logic [4:0]  issue_dest;

  typedef struct {
    string       tag;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        bsy_a;
    logic        bsy_b;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_regs [32];
  logic        m_busy [32];
  int          n_checks = 0;
  int          n_pass   = 0;

  register_file_sb dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .read_addr_a  (read_addr_a),
    .read_addr_b  (read_addr_b),
    .read_data_a  (read_data_a),
    .read_data_b  (read_data_b),
    .busy_a       (busy_a),
    .busy_b       (busy_b),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .issue_valid  (issue_valid),
    .issue_dest   (issue_dest)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (write_enable && write_addr == ra) return write_data;
    return m_regs[ra];
  endfunction

  function automatic logic model_busy(input logic [4:0] ra);
    if (write_enable && write_addr == ra) return 1'b0;
    return m_busy[ra];
  endfunction

  task automatic push_expect(input string tag);
    exp_t e;
    e.tag    = tag;
    e.data_a = model_read(read_addr_a);
    e.data_b = model_read(read_addr_b);
    e.bsy_a  = model_busy(read_addr_a);
    e.bsy_b  = model_busy(read_addr_b);
    sb_q.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_rda"}, read_data_a, e.data_a);
      check({e.tag, "_rdb"}, read_data_b, e.data_b);
      check({e.tag, "_bsa"}, {31'd0, busy_a}, {31'd0, e.bsy_a});
      check({e.tag, "_bsb"}, {31'd0, busy_b}, {31'd0, e.bsy_b});
    end
  endtask

  // Drive one cycle's inputs and check combinational outputs before the edge.
  task automatic pre(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic iv, input logic [4:0] id, input logic [4:0] ra, input logic [4:0] rb);
    write_enable = we;
    write_addr   = wa;
    write_data   = wd;
    issue_valid  = iv;
    issue_dest   = id;
    read_addr_a  = ra;
    read_addr_b  = rb;
    #1;
    push_expect(tag);
    #1;
    pop_compare();
  endtask

  // Take the clock edge and advance the model with the values just applied.
  task automatic post();
    logic        we, iv;
    logic [4:0]  wa, id;
    logic [31:0] wd;
    we = write_enable; wa = write_addr; wd = write_data;
    iv = issue_valid;  id = issue_dest;
    @(posedge clock);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (we && wa != 5'd0) begin
        m_regs[wa] = wd;
        m_busy[wa] = 1'b0;
      end
      if (iv && id != 5'd0) m_busy[id] = 1'b1;
    end
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    model_reset();
    @(posedge clock);
    #1;

    // reset held, then released with no writes
    pre("rst_hold", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd31);
    check("rst_hold_rd5", read_data_a, 32'h0);
    post();
    reset_n = 1'b1;
    pre("post_rst", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd31); post();
    pre("post_rst2", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd5); post();

    // plain write then read
    pre("wr3", 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 5'd1, 5'd2); post();
    pre("rd3", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    check("rd3_const", read_data_a, 32'hDEADBEEF);
    check("rd0_const", read_data_b, 32'h0);
    post();

    // zero register ignores writes and issues
    pre("wr0", 1'b1, 5'd0, 32'h0000BABE, 1'b1, 5'd0, 5'd0, 5'd0);
    check("wr0_byp", read_data_a, 32'h0);
    post();
    pre("rd0", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3);
    check("rd0_after", read_data_a, 32'h0);
    check("rd0_busy", {31'd0, busy_a}, 32'd0);
    post();

    // same-cycle bypass
    pre("byp7", 1'b1, 5'd7, 32'h1111BABE, 1'b0, 5'd0, 5'd7, 5'd7);
    check("byp7_const", read_data_a, 32'h1111BABE);
    post();

    // scoreboard set / clear / priority
    pre("iss9", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd3);
    check("iss9_same_cycle", {31'd0, busy_a}, 32'd0);
    post();
    pre("busy9", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    check("busy9_set", {31'd0, busy_a}, 32'd1);
    post();
    pre("wb9", 1'b1, 5'd9, 32'h00000099, 1'b0, 5'd0, 5'd9, 5'd3);
    check("wb9_resolved", {31'd0, busy_a}, 32'd0);
    post();
    pre("after9", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    check("after9_clear", {31'd0, busy_a}, 32'd0);
    post();
    pre("iss9b", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0); post();
    pre("simul9", 1'b1, 5'd9, 32'h00000999, 1'b1, 5'd9, 5'd9, 5'd9); post();
    pre("prio9", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    check("prio9_busy", {31'd0, busy_a}, 32'd1);
    post();
    pre("iss10", 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd10, 5'd11); post();
    pre("mix1011", 1'b1, 5'd10, 32'h0000AAAA, 1'b1, 5'd11, 5'd3, 5'd4); post();
    pre("chk1011", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd11);
    check("b10_clear", {31'd0, busy_a}, 32'd0);
    check("b11_set", {31'd0, busy_b}, 32'd1);
    post();

    // asynchronous reset between edges
    pre("wr2", 1'b1, 5'd2, 32'h22222222, 1'b0, 5'd0, 5'd2, 5'd4); post();
    pre("wr4", 1'b1, 5'd4, 32'h44444444, 1'b1, 5'd4, 5'd2, 5'd4); post();
    pre("pre_rst", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd4);
    check("pre_rst_rd2", read_data_a, 32'h22222222);
    check("pre_rst_b4", {31'd0, busy_b}, 32'd1);
    reset_n = 1'b0;
    model_reset();
    #1;
    push_expect("async_rst");
    pop_compare();
    check("async_rd2", read_data_a, 32'h0);
    check("async_b4", {31'd0, busy_b}, 32'd0);
    post();
    reset_n = 1'b1;
    pre("rst_rel", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd3); post();

    // random traffic on a small address set to force collisions
    for (int i = 0; i < 300; i++) begin
      logic [4:0] a[5];
      for (int k = 0; k < 5; k++) begin
        a[k] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
      end
      pre("rnd", 1'($urandom_range(0, 1)), a[0], $urandom, 1'($urandom_range(0, 1)), a[1], a[2], a[3]);
      post();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
